// File: rtl/i2s_feed_fifo_pkg.sv
// Shared constants and types for the I2S feed FIFO.
package i2s_feed_fifo_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int SAMPLE_W   = 24;

    // One stereo frame as it is held in the buffer.
    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2s_feed_fifo_mem.sv
// Register array backing the stereo FIFO: one write port, combinational read.
// Contents are not reset; validity is tracked by the pointers in the top.
module i2s_feed_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming frame at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_feed_fifo.sv
// Stereo sample buffer between the DSP stage and the I2S unit. Absorbs timing
// jitter, returns silence on underrun, drops on overflow, sticky status flags.
module i2s_feed_fifo
    import i2s_feed_fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int DW    = SAMPLE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   play_in,
    input  logic                   tick_in,
    input  logic [DW-1:0]          audio0_in,
    input  logic [DW-1:0]          audio1_in,
    input  logic                   req_in,
    output logic                   tick_out,
    output logic [DW-1:0]          audio0_out,
    output logic [DW-1:0]          audio1_out,
    input  logic                   clr_status_in,
    output logic [$clog2(DEPTH):0] level_out,
    output logic                   underrun_out,
    output logic                   overflow_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [AW-1:0]   wptr_reg;
    logic [AW-1:0]   rptr_reg;
    logic [LW-1:0]   level_reg;
    logic [2*DW-1:0] mem_rdata;

    logic rd_req, wr_req, empty, full;
    logic do_rd, do_wr, underrun_set, overflow_set;

    // Standby masks both strobes. A read on a full FIFO frees the slot the
    // same-cycle write needs, so that write is still accepted.
    assign rd_req       = play_in & req_in;
    assign wr_req       = play_in & tick_in;
    assign empty        = (level_reg == '0);
    assign full         = (level_reg == FULL_LEVEL);
    assign do_rd        = rd_req & ~empty;
    assign do_wr        = wr_req & (~full | do_rd);
    assign underrun_set = rd_req & empty;
    assign overflow_set = wr_req & full & ~do_rd;

    assign level_out = level_reg;

    i2s_feed_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2 * DW)
    ) u_mem (
        .clk   (clk),
        .we    (do_wr),
        .waddr (wptr_reg),
        .wdata ({audio0_in, audio1_in}),
        .raddr (rptr_reg),
        .rdata (mem_rdata)
    );

    // Pointers, occupancy and the output frame register; standby flushes all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg   <= '0;
            rptr_reg   <= '0;
            level_reg  <= '0;
            tick_out   <= 1'b0;
            audio0_out <= '0;
            audio1_out <= '0;
        end else if (!play_in) begin
            wptr_reg   <= '0;
            rptr_reg   <= '0;
            level_reg  <= '0;
            tick_out   <= 1'b0;
            audio0_out <= '0;
            audio1_out <= '0;
        end else begin
            tick_out <= rd_req;
            if (rd_req) begin
                // An empty FIFO still answers the request, with silence.
                audio0_out <= do_rd ? mem_rdata[2*DW-1:DW] : '0;
                audio1_out <= do_rd ? mem_rdata[DW-1:0]    : '0;
            end
            if (do_wr) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
            if (do_rd) begin
                rptr_reg <= rptr_reg + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sticky status: a set event in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_out <= 1'b0;
            overflow_out <= 1'b0;
        end else begin
            underrun_out <= underrun_set | (underrun_out & ~clr_status_in);
            overflow_out <= overflow_set | (overflow_out & ~clr_status_in);
        end
    end

endmodule

// File: tb/tb_i2s_feed_fifo.sv
// Self-checking bench for i2s_feed_fifo: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_i2s_feed_fifo;
    import i2s_feed_fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 24;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          play_in = 1'b0;
    logic          tick_in = 1'b0;
    logic [DW-1:0] audio0_in = '0;
    logic [DW-1:0] audio1_in = '0;
    logic          req_in = 1'b0;
    logic          clr_status_in = 1'b0;
    logic          tick_out;
    logic [DW-1:0] audio0_out;
    logic [DW-1:0] audio1_out;
    logic [LW-1:0] level_out;
    logic          underrun_out;
    logic          overflow_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    stereo_sample_t q[$];
    logic           m_tick;
    logic [DW-1:0]  m_a0, m_a1;
    logic           m_unf, m_ovf;

    i2s_feed_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .play_in       (play_in),
        .tick_in       (tick_in),
        .audio0_in     (audio0_in),
        .audio1_in     (audio1_in),
        .req_in        (req_in),
        .tick_out      (tick_out),
        .audio0_out    (audio0_out),
        .audio1_out    (audio1_out),
        .clr_status_in (clr_status_in),
        .level_out     (level_out),
        .underrun_out  (underrun_out),
        .overflow_out  (overflow_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, "_tick"},  64'(tick_out),     64'(m_tick));
        check_val({tag, "_a0"},    64'(audio0_out),   64'(m_a0));
        check_val({tag, "_a1"},    64'(audio1_out),   64'(m_a1));
        check_val({tag, "_level"}, 64'(level_out),    64'(q.size()));
        check_val({tag, "_unf"},   64'(underrun_out), 64'(m_unf));
        check_val({tag, "_ovf"},   64'(overflow_out), 64'(m_ovf));
    endtask

    task automatic model_reset();
        q.delete();
        m_tick = 1'b0; m_a0 = '0; m_a1 = '0; m_unf = 1'b0; m_ovf = 1'b0;
    endtask

    // Predict the state after the coming clock edge from the applied inputs.
    task automatic model_step();
        stereo_sample_t s;
        bit unf_set = 1'b0;
        bit ovf_set = 1'b0;
        if (!play_in) begin
            q.delete();
            m_tick = 1'b0; m_a0 = '0; m_a1 = '0;
        end else begin
            m_tick = req_in;
            if (req_in) begin
                if (q.size() == 0) begin
                    m_a0 = '0; m_a1 = '0; unf_set = 1'b1;
                end else begin
                    s = q.pop_front();
                    m_a0 = s.left; m_a1 = s.right;
                end
            end
            if (tick_in) begin
                if (q.size() < DEPTH) begin
                    s.left = audio0_in; s.right = audio1_in;
                    q.push_back(s);
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        if (clr_status_in) begin m_unf = 1'b0; m_ovf = 1'b0; end
        if (unf_set) m_unf = 1'b1;
        if (ovf_set) m_ovf = 1'b1;
    endtask

    // Called at a falling edge: apply inputs, predict, check at next falling edge.
    task automatic step(input bit play, input bit tick, input bit req, input bit clr,
                        input logic [DW-1:0] a0, input logic [DW-1:0] a1, input string tag);
        play_in = play; tick_in = tick; req_in = req; clr_status_in = clr;
        audio0_in = a0; audio1_in = a1;
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, tag);
    endtask

    task automatic wr(input logic [DW-1:0] a0, input logic [DW-1:0] a1, input string tag);
        step(1'b1, 1'b1, 1'b0, 1'b0, a0, a1, tag);
    endtask

    task automatic rd(input string tag);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, tag);
    endtask

    initial begin
        logic [DW-1:0] ra0, ra1;
        bit rp, rt, rr, rc;
        int bias_wr, bias_rd;

        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("t0_idle");

        // 1: three writes then three spaced reads
        for (int i = 1; i <= 3; i++) wr(DW'(i), DW'(32'h800000 + i), "t1_wr");
        for (int i = 0; i < 3; i++) begin
            rd("t1_rd");
            idle("t1_gap");
        end

        // 2: overfill, then drain; fifth sample must never appear
        for (int i = 1; i <= 5; i++) wr(DW'(32'h100 + i), DW'(32'h900 + i), "t2_wr");
        for (int i = 0; i < 4; i++) begin
            rd("t2_rd");
            idle("t2_gap");
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, "t2_clr");

        // 3: read on empty gives silence and underrun; clear afterwards
        rd("t3_rd_empty");
        idle("t3_gap");
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, "t3_clr");

        // 4: full FIFO with simultaneous write and read
        for (int i = 1; i <= 4; i++) wr(DW'(32'h200 + i), DW'(32'hA00 + i), "t4_fill");
        step(1'b1, 1'b1, 1'b1, 1'b0, DW'(32'h205), DW'(32'hA05), "t4_both");
        idle("t4_gap");
        for (int i = 0; i < 4; i++) rd("t4_drain");
        idle("t4_end");

        // Simultaneous write and read on empty: silence, no bypass
        step(1'b1, 1'b1, 1'b1, 1'b0, DW'(32'h300), DW'(32'hB00), "t4_empty_both");
        rd("t4_empty_after");
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, "t4_clr");

        // 5: standby flush with a request in the last play cycle
        wr(DW'(32'h401), DW'(32'hC01), "t5_wr");
        wr(DW'(32'h402), DW'(32'hC02), "t5_wr");
        rd("t5_last_req");
        step(1'b0, 1'b1, 1'b1, 1'b0, DW'(32'h4FF), DW'(32'hCFF), "t5_standby");
        idle("t5_resume");
        idle("t5_resume2");

        // Randomized traffic with phases biased toward full or empty
        for (int ph = 0; ph < 12; ph++) begin
            bias_wr = $urandom_range(20, 80);
            bias_rd = $urandom_range(20, 80);
            for (int c = 0; c < 50; c++) begin
                rp  = ($urandom_range(0, 99) < 95);
                rt  = ($urandom_range(0, 99) < bias_wr);
                rr  = ($urandom_range(0, 99) < bias_rd) && !req_in;
                rc  = ($urandom_range(0, 99) < 5);
                ra0 = DW'($urandom);
                ra1 = DW'($urandom);
                step(rp, rt, rr, rc, ra0, ra1, "rand");
            end
        end

        // 6: async reset with level 3 and tick_out high
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, "t6_pre");
        for (int i = 1; i <= 4; i++) wr(DW'(32'h600 + i), DW'(32'hE00 + i), "t6_fill");
        rd("t6_rd");
        check_val("t6_tick_high", 64'(tick_out), 64'(1));
        play_in = 1'b1; tick_in = 1'b0; req_in = 1'b0; clr_status_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        idle("t6_after");
        wr(DW'(32'h7AB), DW'(32'hF12), "t6_wr");
        rd("t6_rd2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_feed_fifo.md
Name: i2s_feed_fifo

Overview:
- Stereo sample buffer directly upstream of the I2S unit.
- Accepts 24-bit left/right sample pairs from the DSP stage on a one-cycle tick. Stores them in a small FIFO. Presents one pair to the I2S unit with a one-cycle tick_out pulse for each req_in pulse the I2S unit raises.
- Absorbs jitter between DSP output timing and the I2S frame request timing.
- Reports underrun and overflow to the control unit as sticky status bits.

Parameters:
- DEPTH, 4, FIFO depth in stereo pairs; power of two, 2..16.
- DW, 24, audio sample width per channel.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- play_in  in  1  play mode; low = standby, FIFO flushed
- tick_in  in  1  one-cycle write strobe from DSP
- audio0_in  in  DW  left sample, valid when tick_in=1
- audio1_in  in  DW  right sample, valid when tick_in=1
- req_in  in  1  one-cycle request from I2S unit (its req_out)
- tick_out  out  1  one-cycle pulse to I2S unit tick_in
- audio0_out  out  DW  left sample to I2S unit
- audio1_out  out  DW  right sample to I2S unit
- clr_status_in  in  1  one-cycle pulse; clears sticky flags
- level_out  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- underrun_out  out  1  sticky: req_in arrived while empty
- overflow_out  out  1  sticky: tick_in arrived while full

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FIFO pointers 0; level 0; flags 0.
  - Output registers audio0_out/audio1_out are 0.
- Storage:
  - Array of DEPTH entries, each {audio0,audio1} = 2*DW bits.
  - Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is separate; full = (level==DEPTH), empty = (level==0).
- Write (cycle N, tick_in=1, play_in=1):
  - If not full: entry stored at wptr, wptr++, level++.
  - If full: sample dropped, overflow_out set from N+1. Pointers unchanged.
- Read (cycle N, req_in=1, play_in=1):
  - If not empty: rptr entry loaded into audio0_out/audio1_out at N+1, tick_out=1 at N+1 only, rptr++, level--.
  - If empty: audio0_out/audio1_out load 0, tick_out=1 at N+1 (I2S still receives a frame, silence), underrun_out set from N+1.
  - Latency is exactly 1 cycle req_in -> tick_out.
  - tick_out is never high two consecutive cycles, given that req_in is a pulse.
- Simultaneous write and read in the same cycle:
  - Not empty, not full: both performed, level unchanged.
  - Empty: write is accepted and the read returns silence plus underrun. No bypass of new data.
  - Full: read performed first, so the write is accepted; no overflow, level unchanged.
- Output hold: audio0_out/audio1_out hold their value between tick_out pulses.
- Standby (play_in=0):
  - Synchronous flush: pointers, level, audio0_out/audio1_out go to 0 the next cycle.
  - tick_out is forced 0; tick_in and req_in are ignored.
  - Sticky flags are held (not cleared).
  - play_in falling mid-request: a req_in seen with play_in=1 in cycle N still produces tick_out at N+1, even if play_in=0 at N+1. Flush occurs at the first cycle play_in=0 is sampled.
- Status:
  - clr_status_in clears both flags next cycle.
  - If a set event occurs in the same cycle as clr_status_in, the set wins.
- level_out is registered and reflects state after the current cycle's operations.

Decomposition:
- audioport_pkg additions:
  - FIFO_DEPTH constant (4).
  - typedef stereo_sample_t (packed struct {logic [23:0] left; logic [23:0] right}).
- Sub-module fifo_mem: DEPTH x 2*DW register array with write port and combinational read port; no reset on the array.
- Pointer, level, flag and output logic live in the top module.

Test Plan:
1. Reset then play_in=1; three ticks with (0x000001,0x800001), (0x000002,0x800002), (0x000003,0x800003) -> level_out=3. Three spaced req_in pulses give tick_out one cycle after each, with outputs in that order; level_out ends 0; no flags.
2. DEPTH=4; five ticks with no req_in -> level_out=4 and overflow_out=1 after the fifth. Subsequent reads return samples 1..4; the fifth sample is never output.
3. Empty FIFO, req_in pulse -> tick_out=1 next cycle, audio0_out=audio1_out=0, underrun_out=1. clr_status_in pulse -> underrun_out=0 next cycle.
4. Full FIFO, tick_in and req_in in the same cycle -> oldest sample output, new sample accepted, level_out stays 4, overflow_out stays 0.
5. Level 2, drop play_in for one cycle -> level_out=0, outputs 0, tick_out never asserted while play_in=0. A req_in in the last play cycle still yields one tick_out.
6. Assert rst_n=0 asynchronously mid-stream with level 3 and tick_out high -> all outputs 0 immediately, without waiting for a clk edge; after release level_out=0.
